// File: rtl/gsensor_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : gsensor_spi_responder
// Purpose  : SPI mode-3 target emulating the ADXL345 register subset used by
//            the DE10-Lite accelerometer path. Serves X/Y/Z samples from
//            parallel inputs through a coherent shadow and raises DATA_READY.
//            All logic runs in the clk domain by oversampling the SPI pins.
// Optional : define GSENSOR_RESP_INT_EN to enable INT_ENABLE, INT_SOURCE and
//            the INT1 (interrupt[1]) output; otherwise interrupt is 2'b00.
// Ports    : clk, reset_n (async, active low)
//            SPI_CLK, SPI_CSN, SPI_SDI  - SPI pins from the master
//            SPI_SDO, SPI_SDO_OE        - MISO data and its output enable
//            sample_x/y/z, sample_valid - new sample set (16-bit 2's compl.)
//            interrupt[2:1]             - bit1 DATA_READY, bit2 held 0
// Revision : 1.0 - initial release
// ============================================================================
module gsensor_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SPI_CLK,
    input  logic        SPI_CSN,
    input  logic        SPI_SDI,
    output logic        SPI_SDO,
    output logic        SPI_SDO_OE,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic [2:1]  interrupt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_RD   = 2'd2,
        S_WR   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic                   sclk_prev_q;
    logic                   csn_prev_q;

    // CSN synchronizer resets to "selected" so a CSN already low when reset
    // releases never looks like a falling edge: a fresh select is required.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '1;
            csn_sync_q  <= '0;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b1;
            csn_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], SPI_CSN};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], SPI_SDI};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, csn_s, sdi_s;
    logic sclk_rise, sclk_fall, csn_rise, csn_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csn_rise  = csn_s & ~csn_prev_q;
    assign csn_fall  = ~csn_s & csn_prev_q;

    // ------------------------------------------------------------------
    // Transaction state
    // ------------------------------------------------------------------
    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_in_q;
    logic [7:0] sdo_sh_q;
    logic       sdo_q;
    logic       oe_q;
    logic       mb_q;
    logic [5:0] addr_q;

    logic [7:0] shift_next;
    logic [7:0] rd_data;

    assign shift_next = {shift_in_q[6:0], sdi_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_in_q <= 8'h00;
            sdo_sh_q   <= 8'h00;
            sdo_q      <= 1'b0;
            oe_q       <= 1'b0;
            mb_q       <= 1'b0;
            addr_q     <= 6'h00;
        end else if (csn_s) begin
            // Deselect aborts everything; a partial byte is simply dropped.
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            sdo_q     <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (csn_fall) begin
                        state_q   <= S_CMD;
                        bit_cnt_q <= 3'd0;
                    end
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        shift_in_q <= shift_next;
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            mb_q    <= shift_next[6];
                            addr_q  <= shift_next[5:0];
                            state_q <= shift_next[7] ? S_RD : S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (sclk_fall) begin
                        // First fall of a byte fetches the register and
                        // presents its MSB; later falls shift the rest out.
                        if (bit_cnt_q == 3'd0) begin
                            sdo_q    <= rd_data[7];
                            sdo_sh_q <= {rd_data[6:0], 1'b0};
                            oe_q     <= 1'b1;
                        end else begin
                            sdo_q    <= sdo_sh_q[7];
                            sdo_sh_q <= {sdo_sh_q[6:0], 1'b0};
                        end
                    end else if (sclk_rise) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if ((bit_cnt_q == 3'd7) && mb_q) begin
                            addr_q <= addr_q + 6'd1;
                        end
                    end
                end
                S_WR: begin
                    if (sclk_rise) begin
                        shift_in_q <= shift_next;
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if ((bit_cnt_q == 3'd7) && mb_q) begin
                            addr_q <= addr_q + 6'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign SPI_SDO    = sdo_q;
    assign SPI_SDO_OE = oe_q;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [7:0] bw_rate_q;
    logic [7:0] power_ctl_q;
    logic [7:0] data_format_q;
    logic       wr_en;

    // Write uses the address before any multi-byte increment.
    assign wr_en = (state_q == S_WR) && sclk_rise && (bit_cnt_q == 3'd7) && !csn_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bw_rate_q     <= 8'h0A;
            power_ctl_q   <= 8'h00;
            data_format_q <= 8'h00;
        end else if (wr_en) begin
            case (addr_q)
                6'h2C:   bw_rate_q     <= shift_next;
                6'h2D:   power_ctl_q   <= shift_next;
                6'h31:   data_format_q <= shift_next;
                default: ;
            endcase
        end
    end

`ifdef GSENSOR_RESP_INT_EN
    logic [7:0] int_enable_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_enable_q <= 8'h00;
        end else if (wr_en && (addr_q == 6'h2E)) begin
            int_enable_q <= shift_next;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sample shadow, pending sample and DATA_READY
    // ------------------------------------------------------------------
    logic [47:0] shadow_q, shadow_d;
    logic [47:0] pend_q, pend_d;
    logic        pending_q, pending_d;
    logic        dr_q, dr_d;
    logic        touched_q, touched_d;
    logic        sv_meas;
    logic        addr_is_data;
    logic        rd_load;

    assign sv_meas      = sample_valid & power_ctl_q[3];
    assign addr_is_data = (addr_q >= 6'h32) && (addr_q <= 6'h37);
    assign rd_load      = (state_q == S_RD) && sclk_fall && (bit_cnt_q == 3'd0) && !csn_s;

    always_comb begin
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        dr_d      = dr_q;
        touched_d = touched_q;
        if (csn_rise) begin
            // End of transaction: deliver any held sample. A new load sets
            // DATA_READY, which takes precedence over the read-clear.
            touched_d = 1'b0;
            pending_d = 1'b0;
            if (sv_meas) begin
                shadow_d = {sample_z, sample_y, sample_x};
                dr_d     = 1'b1;
            end else if (pending_q) begin
                shadow_d = pend_q;
                dr_d     = 1'b1;
            end else if (touched_q) begin
                dr_d     = 1'b0;
            end
        end else begin
            if (rd_load && addr_is_data) begin
                touched_d = 1'b1;
            end
            if (sv_meas) begin
                // Keep a multi-byte data read coherent: defer the update.
                if (touched_q) begin
                    pend_d    = {sample_z, sample_y, sample_x};
                    pending_d = 1'b1;
                end else begin
                    shadow_d = {sample_z, sample_y, sample_x};
                    dr_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q  <= 48'h0;
            pend_q    <= 48'h0;
            pending_q <= 1'b0;
            dr_q      <= 1'b0;
            touched_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            dr_q      <= dr_d;
            touched_q <= touched_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = 8'h00;
        case (addr_q)
            6'h00: rd_data = DEVID;
            6'h2C: rd_data = bw_rate_q;
            6'h2D: rd_data = power_ctl_q;
`ifdef GSENSOR_RESP_INT_EN
            6'h2E: rd_data = int_enable_q;
            6'h30: rd_data = {dr_q, 7'b0};
`endif
            6'h31: rd_data = data_format_q;
            6'h32: rd_data = shadow_q[7:0];
            6'h33: rd_data = shadow_q[15:8];
            6'h34: rd_data = shadow_q[23:16];
            6'h35: rd_data = shadow_q[31:24];
            6'h36: rd_data = shadow_q[39:32];
            6'h37: rd_data = shadow_q[47:40];
            default: rd_data = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
`ifdef GSENSOR_RESP_INT_EN
    logic int1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int1_q <= 1'b0;
        end else begin
            int1_q <= dr_q & int_enable_q[7] & power_ctl_q[3];
        end
    end

    assign interrupt = {1'b0, int1_q};
`else
    assign interrupt = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gsensor_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gsensor_spi_responder
// Purpose  : Directed self-checking bench for gsensor_spi_responder. Acts as
//            a mode-3 SPI master (SPI clock = clk/16) and compares returned
//            bytes and pin states against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gsensor_spi_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        SPI_CLK;
    logic        SPI_CSN;
    logic        SPI_SDI;
    logic        SPI_SDO;
    logic        SPI_SDO_OE;
    logic [15:0] sample_x;
    logic [15:0] sample_y;
    logic [15:0] sample_z;
    logic        sample_valid;
    logic [2:1]  interrupt;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_buf [0:7];
    logic [7:0] exp6   [0:5];
    logic       cmd_oe_any;
    logic       data_oe_all;

`ifdef GSENSOR_RESP_INT_EN
    localparam logic [7:0] C_DR_SET  = 8'h80;
    localparam logic [7:0] C_INTEN   = 8'h80;
    localparam logic [1:0] C_INT_HI  = 2'b01;
`else
    localparam logic [7:0] C_DR_SET  = 8'h00;
    localparam logic [7:0] C_INTEN   = 8'h00;
    localparam logic [1:0] C_INT_HI  = 2'b00;
`endif

    gsensor_spi_responder #(
        .DEVID       (8'hE5),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .SPI_CLK      (SPI_CLK),
        .SPI_CSN      (SPI_CSN),
        .SPI_SDI      (SPI_SDI),
        .SPI_SDO      (SPI_SDO),
        .SPI_SDO_OE   (SPI_SDO_OE),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_z     (sample_z),
        .sample_valid (sample_valid),
        .interrupt    (interrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Half SPI period: 8 clk cycles, inputs change 1 ns after a clk edge.
    task automatic half();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx,
                            output logic oe_any, output logic oe_all);
        rx     = 8'h00;
        oe_any = 1'b0;
        oe_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            SPI_SDI = tx[7-i];
            SPI_CLK = 1'b0;
            half();
            rx      = {rx[6:0], SPI_SDO};
            oe_any  = oe_any | SPI_SDO_OE;
            oe_all  = oe_all & SPI_SDO_OE;
            SPI_CLK = 1'b1;
            half();
        end
    endtask

    task automatic sv_pulse();
        @(posedge clk); #1;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    // Full transaction; sv_after >= 0 pulses sample_valid after that data byte.
    task automatic xfer(input logic [7:0] cmd, input int nbytes, input logic [7:0] wdata,
                        input int sv_after);
        logic [7:0] rx;
        logic       any_b, all_b;
        SPI_CSN = 1'b0;
        half();
        spi_bits(cmd, 8, rx, any_b, all_b);
        cmd_oe_any  = any_b;
        data_oe_all = 1'b1;
        for (int b = 0; b < nbytes; b++) begin
            spi_bits(wdata, 8, rx, any_b, all_b);
            rx_buf[b]   = rx;
            data_oe_all = data_oe_all & all_b;
            if (b == sv_after) sv_pulse();
        end
        half();
        SPI_CSN = 1'b1;
        half();
        half();
    endtask

    task automatic check6(input string tag);
        for (int i = 0; i < 6; i++) check($sformatf("%s[%0d]", tag, i), {8'h00, rx_buf[i]}, {8'h00, exp6[i]});
    endtask

    initial begin
        logic [7:0] rx;
        logic       any_b, all_b;

        reset_n      = 1'b0;
        SPI_CLK      = 1'b1;
        SPI_CSN      = 1'b1;
        SPI_SDI      = 1'b0;
        sample_x     = 16'h0;
        sample_y     = 16'h0;
        sample_z     = 16'h0;
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sdo", {15'h0, SPI_SDO}, 16'h0);
        check("rst_oe", {15'h0, SPI_SDO_OE}, 16'h0);
        check("rst_int", {14'h0, interrupt}, 16'h0);
        reset_n = 1'b1;
        half();

        // DEVID read and SDO_OE framing
        xfer(8'h80, 1, 8'h00, -1);
        check("devid", {8'h0, rx_buf[0]}, 16'h00E5);
        check("oe_cmd_low", {15'h0, cmd_oe_any}, 16'h0);
        check("oe_data_high", {15'h0, data_oe_all}, 16'h1);
        check("oe_after_csn", {15'h0, SPI_SDO_OE}, 16'h0);

        xfer(8'hAC, 1, 8'h00, -1);
        check("bw_rate_rst", {8'h0, rx_buf[0]}, 16'h000A);

        xfer(8'h2D, 1, 8'h08, -1);
        xfer(8'hAD, 1, 8'h00, -1);
        check("power_ctl", {8'h0, rx_buf[0]}, 16'h0008);

        // Sample load and multi-byte read
        sample_x = 16'h0123;
        sample_y = 16'hFFF0;
        sample_z = 16'h0100;
        sv_pulse();
        xfer(8'hB0, 1, 8'h00, -1);
        check("int_src_set", {8'h0, rx_buf[0]}, {8'h0, C_DR_SET});
        xfer(8'hF2, 6, 8'h00, -1);
        exp6[0] = 8'h23; exp6[1] = 8'h01; exp6[2] = 8'hF0;
        exp6[3] = 8'hFF; exp6[4] = 8'h00; exp6[5] = 8'h01;
        check6("mb_read");
        xfer(8'hB0, 1, 8'h00, -1);
        check("int_src_clr", {8'h0, rx_buf[0]}, 16'h0000);

        // New sample mid-read: old data stays coherent, new one lands after
        sample_x = 16'h0555;
        xfer(8'hF2, 6, 8'h00, 1);
        check6("coherent");
        xfer(8'hB0, 1, 8'h00, -1);
        check("int_src_pend", {8'h0, rx_buf[0]}, {8'h0, C_DR_SET});
        xfer(8'hF2, 6, 8'h00, -1);
        exp6[0] = 8'h55; exp6[1] = 8'h05;
        check6("new_sample");

        // MB=0 repeats the address; MB=1 wraps 0x3F -> 0x00
        xfer(8'hB3, 2, 8'h00, -1);
        check("mb0_b0", {8'h0, rx_buf[0]}, 16'h0005);
        check("mb0_b1", {8'h0, rx_buf[1]}, 16'h0005);
        xfer(8'hFF, 2, 8'h00, -1);
        check("wrap_3f", {8'h0, rx_buf[0]}, 16'h0000);
        check("wrap_00", {8'h0, rx_buf[1]}, 16'h00E5);

        // MEASURE=0 ignores sample_valid
        xfer(8'h2D, 1, 8'h00, -1);
        sample_x = 16'h7777;
        sv_pulse();
        xfer(8'hB2, 1, 8'h00, -1);
        check("measure_off", {8'h0, rx_buf[0]}, 16'h0055);

        // Aborted write after 5 data bits
        SPI_CSN = 1'b0;
        half();
        spi_bits(8'h2C, 8, rx, any_b, all_b);
        spi_bits(8'hFF, 5, rx, any_b, all_b);
        half();
        SPI_CSN = 1'b1;
        half();
        half();
        xfer(8'hAC, 1, 8'h00, -1);
        check("partial_wr", {8'h0, rx_buf[0]}, 16'h000A);

        // INT_ENABLE and INT1
        xfer(8'h2E, 1, 8'h80, -1);
        xfer(8'hAE, 1, 8'h00, -1);
        check("int_enable", {8'h0, rx_buf[0]}, {8'h0, C_INTEN});
        xfer(8'h2D, 1, 8'h08, -1);
        check("int_idle", {14'h0, interrupt}, 16'h0);
        sv_pulse();
        @(posedge clk); #1;
        check("int_rise", {14'h0, interrupt}, {14'h0, C_INT_HI});

        // Reset in the middle of a read data byte
        SPI_CSN = 1'b0;
        half();
        spi_bits(8'h80, 8, rx, any_b, all_b);
        spi_bits(8'h00, 3, rx, any_b, all_b);
        check("mid_sdo", {15'h0, SPI_SDO}, 16'h1);
        check("mid_oe", {15'h0, SPI_SDO_OE}, 16'h1);
        reset_n = 1'b0;
        #1;
        check("arst_sdo", {15'h0, SPI_SDO}, 16'h0);
        check("arst_oe", {15'h0, SPI_SDO_OE}, 16'h0);
        check("arst_int", {14'h0, interrupt}, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        spi_bits(8'h80, 8, rx, any_b, all_b);
        spi_bits(8'h00, 8, rx, any_b, all_b);
        check("no_fresh_edge", {15'h0, any_b}, 16'h0);
        half();
        SPI_CSN = 1'b1;
        half();
        half();
        xfer(8'h80, 1, 8'h00, -1);
        check("devid_after_rst", {8'h0, rx_buf[0]}, 16'h00E5);
        xfer(8'hAD, 1, 8'h00, -1);
        check("pwr_after_rst", {8'h0, rx_buf[0]}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/gsensor_spi_responder.md
# gsensor_spi_responder

SPI target that emulates the DE10-Lite accelerometer (ADXL345 register subset) so that `spi_control` and the accel display path can run in simulation, or on a second board, without the physical sensor. It answers 4-wire SPI mode 3 transactions from the existing master. It serves X/Y/Z samples supplied on parallel inputs and raises a data-ready interrupt. It runs entirely in the `clk` domain by oversampling the SPI pins.

## Interface
- `DEVID`, 8'hE5: value returned at address 0x00.
- `SYNC_STAGES`, 2: synchronizer depth on `SPI_CLK`, `SPI_CSN` and `SPI_SDI`; minimum 2.
- `clk` input 1: system clock; must be ≥ 8× the SPI clock frequency.
- `reset_n` input 1: asynchronous, active-low reset.
- `SPI_CLK` input 1: SPI clock from the master; idles high (CPOL=1, CPHA=1).
- `SPI_CSN` input 1: chip select, active low.
- `SPI_SDI` input 1: master-to-target data (MOSI).
- `SPI_SDO` output 1: target-to-master data (MISO).
- `SPI_SDO_OE` output 1: high while the target drives `SPI_SDO`.
- `sample_x`, `sample_y`, `sample_z` input 16 each: two's-complement samples.
- `sample_valid` input 1: one-cycle strobe that presents a new sample set.
- `interrupt` output [2:1]: bit 1 is DATA_READY (INT1); bit 2 is held 0.

## Operation
- Transactions are framed by `SPI_CSN` low. The first byte is the command: bit7 R/W (1 = read), bit6 MB (multi-byte), bits5:0 address. Remaining bytes are data, MSB first.
- Input sampling: SDI is captured on the synchronized `SPI_CLK` rising edge. SDO shifts on the synchronized falling edge.
- State machine:
  - IDLE: `SPI_CSN` low → CMD, bit count cleared.
  - CMD: after 8 rising edges, latch the command → RD or WR.
  - RD: on each byte's first falling edge, load shift register with reg[addr] and drive bit7. Later falls shift out.
  - WR: after 8 rising edges, write the byte to reg[addr].
  - After each data byte in RD or WR: if MB=1, addr ← addr+1, wrapping 0x3F→0x00. If MB=0, addr is unchanged, so the same register repeats.
  - Any state: `SPI_CSN` high → IDLE. A partial byte is discarded and no write occurs.
- Register map (other addresses read 0x00, writes ignored):
  - 0x00 DEVID: read-only.
  - 0x2C BW_RATE: reset 0x0A.
  - 0x2D POWER_CTL: reset 0x00; bit3 = MEASURE.
  - 0x2E INT_ENABLE: reset 0x00; bit7 = DATA_READY enable.
  - 0x30 INT_SOURCE: read-only; bit7 = data_ready flag.
  - 0x31 DATA_FORMAT: reset 0x00; bits[7:6] read as written, no functional effect.
  - 0x32..0x37 DATAX0, DATAX1, DATAY0, DATAY1, DATAZ0, DATAZ1: read-only shadow bytes, low byte first.
- Shadow update:
  - On `sample_valid` with MEASURE=1, load the shadow and set data_ready.
  - If a read transaction has touched 0x32..0x37 and `SPI_CSN` is still low, hold the sample as pending. Load it at `SPI_CSN` rise, so multi-byte reads stay coherent.
  - A newer `sample_valid` overwrites the pending sample.
  - With MEASURE=0, `sample_valid` is ignored.
- data_ready clears at `SPI_CSN` rise when the transaction read any of 0x32..0x37.
- Same-cycle data_ready clear and set (from pending or a simultaneous `sample_valid`): set wins.
- Reset values:
  - `SPI_SDO`=0, `SPI_SDO_OE`=0, `interrupt`=2'b00.
  - All registers at their reset values; shadow, pending and data_ready cleared.
- Reset asserted mid-transaction: immediate return to IDLE with outputs at reset values. The next transaction requires a fresh `SPI_CSN` falling edge.

## Timing
- Input latency: SYNC_STAGES cycles plus 1 edge-detect cycle from a pin edge to the internal event.
- SDO: valid within SYNC_STAGES+2 `clk` cycles of an `SPI_CLK` falling edge. It must be stable before the next rising edge, guaranteed by the 8× rule.
- `SPI_SDO_OE`: rises with the first data-byte falling edge in RD. Falls within SYNC_STAGES+2 cycles of `SPI_CSN` high.
- Register write: takes effect 1 cycle after the 8th rising edge of the data byte.
- `interrupt[1]`: registered, 1 cycle after a data_ready or enable change.

## Configuration
- `GSENSOR_RESP_INT_EN` defined:
  - `interrupt[1]` = data_ready & INT_ENABLE[7] & MEASURE.
  - INT_SOURCE bit7 reports data_ready.
- `GSENSOR_RESP_INT_EN` undefined:
  - `interrupt` is tied to 2'b00.
  - INT_SOURCE reads 0x00 and INT_ENABLE reads 0x00, writes ignored.
  - The data_ready flag and the shadow/pending behaviour remain.

## Test plan
- Read 0x00 (command 0x80) → master receives 0xE5. `SPI_SDO_OE` is high only during the data byte.
- Write POWER_CTL: command 0x2D, data 0x08 → read back 0x08.
- Sample X=0x0123, Y=0xFFF0, Z=0x0100 with MEASURE=1; multi-byte read from 0x32 (command 0xF2), 6 bytes → 23 01 F0 FF 00 01. data_ready clears at `SPI_CSN` rise.
- Issue `sample_valid` with X=0x0555 after the 2nd byte of a 6-byte read of old X=0x0123 → bytes return the old sample. The next read returns 0x0555, and data_ready stays set.
- Write 0x2C with `SPI_CSN` raised after 5 data bits → BW_RATE remains 0x0A. The next transaction decodes normally.
- With `GSENSOR_RESP_INT_EN` defined, INT_ENABLE=0x80 and MEASURE=1, pulse `sample_valid` → `interrupt[1]` high 1 cycle later. `reset_n` low → `interrupt`=00 immediately.
